// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared definitions for the K=3 convolutional encoder and the
// Viterbi decoder datapath (ACS, branch metrics, traceback).
package viterbi_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  // Generator taps, MSB = newest bit u, then s1, then s0.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Trellis state {s1,s0}; s1 is the most recent information bit.
  typedef logic [K-2:0] trellis_state_t;

  // Encoder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_fsm_t;

  // Channel symbol {g0,g1}.
  typedef struct packed {
    logic g0;
    logic g1;
  } symbol_t;

endpackage

// File: rtl/conv_enc_branch.sv
// conv_enc_branch: one trellis branch, (state, u) -> (symbol, next state).
// Purely combinational so the decoder side can reuse it as a reference.
module conv_enc_branch
  import viterbi_pkg::*;
(
  input  logic           u,
  input  trellis_state_t state,
  output symbol_t        sym,
  output trellis_state_t next_state
);

  // Shift-register window {u, s1, s0}.
  logic [K-1:0] window;
  logic [1:0]   sym_bits;

  assign window = {u, state};

  // Each output bit is the parity of the window masked by its generator;
  // sym_bits[1] carries g0, sym_bits[0] carries g1.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tap
      localparam logic [K-1:0] GEN = (gi == 0) ? G0 : G1;
      assign sym_bits[1-gi] = ^(window & GEN);
    end
  endgenerate

  assign sym        = symbol_t'(sym_bits);
  assign next_state = window[K-1:1];

endmodule

// File: rtl/conv_enc_k3.sv
// conv_enc_k3: rate-1/2, K=3 convolutional encoder (G0=7, G1=5) with
// valid/ready framing, a single-stage output register and optional
// two-bit zero tail per frame (TERM_EN).
// Build option: define CONV_ENC_STATS_EN to add the frame_cnt / sym_cnt
// statistics outputs.
module conv_enc_k3
  import viterbi_pkg::*;
#(
  parameter bit TERM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       out_tail,
  output logic [1:0] enc_state,
  output logic       busy
`ifdef CONV_ENC_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] sym_cnt
`endif
);

  enc_fsm_t       fsm_reg;
  trellis_state_t enc_state_reg;
  logic [1:0]     tail_cnt_reg;
  logic           out_valid_reg;
  symbol_t        out_sym_reg;
  logic           out_last_reg;
  logic           out_tail_reg;

  logic           out_load;
  logic           in_accept;
  logic           branch_u;
  symbol_t        branch_sym;
  trellis_state_t branch_next;

  // The output register may take a new symbol when empty or being drained.
  assign out_load  = !out_valid_reg || out_ready;
  // rst gates in_ready so nothing is offered while reset is held.
  assign in_ready  = !rst && ((fsm_reg == IDLE) || (fsm_reg == DATA)) && out_load;
  assign in_accept = in_valid && in_ready;

  // Tail bits are always zero; otherwise the branch sees the offered bit.
  assign branch_u = (fsm_reg == TAIL) ? 1'b0 : in_bit;

  conv_enc_branch u_branch (
    .u          (branch_u),
    .state      (enc_state_reg),
    .sym        (branch_sym),
    .next_state (branch_next)
  );

  // Control FSM, trellis state and output register all advance together
  // on an output-load opportunity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      enc_state_reg <= '0;
      tail_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sym_reg   <= '0;
      out_last_reg  <= 1'b0;
      out_tail_reg  <= 1'b0;
    end else if (out_load) begin
      if (in_accept) begin
        out_valid_reg <= 1'b1;
        out_sym_reg   <= branch_sym;
        out_tail_reg  <= 1'b0;
        if (in_last && TERM_EN) begin
          fsm_reg       <= TAIL;
          enc_state_reg <= branch_next;
          tail_cnt_reg  <= '0;
          out_last_reg  <= 1'b0;
        end else if (in_last) begin
          // Unterminated frame: next frame restarts from the zero state.
          fsm_reg       <= IDLE;
          enc_state_reg <= '0;
          out_last_reg  <= 1'b1;
        end else begin
          fsm_reg       <= DATA;
          enc_state_reg <= branch_next;
          out_last_reg  <= 1'b0;
        end
      end else if (fsm_reg == TAIL) begin
        out_valid_reg <= 1'b1;
        out_sym_reg   <= branch_sym;
        out_tail_reg  <= 1'b1;
        enc_state_reg <= branch_next;
        if (tail_cnt_reg == 2'(TAIL_LEN - 1)) begin
          // Two zeros have flushed the register, so branch_next is 00 here.
          fsm_reg      <= IDLE;
          tail_cnt_reg <= '0;
          out_last_reg <= 1'b1;
        end else begin
          tail_cnt_reg <= tail_cnt_reg + 2'd1;
          out_last_reg <= 1'b0;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sym   = out_sym_reg;
  assign out_last  = out_last_reg;
  assign out_tail  = out_tail_reg;
  assign enc_state = enc_state_reg;
  assign busy      = (fsm_reg != IDLE) || out_valid_reg;

`ifdef CONV_ENC_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [15:0] sym_cnt_reg;
  logic        restart_reg;
  logic        out_hs;

  assign out_hs = out_valid_reg && out_ready;

  // Frame counter wraps; symbol counter saturates and restarts at the first
  // handshake of the next frame, counting that handshake as symbol 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      sym_cnt_reg   <= '0;
      restart_reg   <= 1'b0;
    end else if (out_hs) begin
      if (out_last_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      if (restart_reg) begin
        sym_cnt_reg <= 16'd1;
      end else if (sym_cnt_reg != 16'hFFFF) begin
        sym_cnt_reg <= sym_cnt_reg + 16'd1;
      end
      restart_reg <= out_last_reg;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign sym_cnt   = sym_cnt_reg;
`endif

endmodule

// File: tb/tb_conv_enc_k3.sv
// tb_conv_enc_k3: two encoder instances (index 0 with tail termination,
// index 1 without), random and directed framed stimulus, and a per-instance
// monitor that checks every output handshake against a frame-level model.
module tb_conv_enc_k3;

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
    logic       tail;
    logic       fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       in_bit   [2];
  logic       in_last  [2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [1:0] out_sym  [2];
  logic       out_last [2];
  logic       out_tail [2];
  logic [1:0] enc_state[2];
  logic       busy     [2];
`ifdef CONV_ENC_STATS_EN
  logic [15:0] frame_cnt[2];
  logic [15:0] sym_cnt  [2];
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[3][$];
  int   ready_mode[2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Frame model: the coded stream is the convolution of the zero-prefixed
  // bit sequence x with the generators; g0 = x[k]^x[k-1]^x[k-2], g1 = x[k]^x[k-2].
  function automatic void model(input int i, input logic [15:0] v, input int n, input bit term);
    logic x[$];
    int   total;
    exp_t e;
    total = n + (term ? 2 : 0);
    x.push_back(1'b0);
    x.push_back(1'b0);
    for (int k = 0; k < n; k++) x.push_back(v[n-1-k]);
    if (term) begin
      x.push_back(1'b0);
      x.push_back(1'b0);
    end
    for (int k = 0; k < total; k++) begin
      e.sym  = {x[k+2] ^ x[k+1] ^ x[k], x[k+2] ^ x[k]};
      e.last = (k == total - 1);
      e.tail = (k >= n);
      e.fin  = (k == n - 1);
      exp_q[i].push_back(e);
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      conv_enc_k3 #(.TERM_EN(gi == 0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_bit    (in_bit[gi]),
        .in_last   (in_last[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_sym   (out_sym[gi]),
        .out_last  (out_last[gi]),
        .out_tail  (out_tail[gi]),
        .enc_state (enc_state[gi]),
        .busy      (busy[gi])
`ifdef CONV_ENC_STATS_EN
        ,
        .frame_cnt (frame_cnt[gi]),
        .sym_cnt   (sym_cnt[gi])
`endif
      );

      int         pat_cnt = 0;
      logic       prev_stall = 1'b0;
      logic [3:0] prev_val = '0;
      exp_t       e;

      // Downstream ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0.
      always @(negedge clk) begin
        case (ready_mode[gi])
          0:       out_ready[gi] = 1'b1;
          1:       out_ready[gi] = ($urandom_range(0, 3) != 0);
          default: begin
            out_ready[gi] = (pat_cnt % 3 == 0);
            pat_cnt++;
          end
        endcase
      end

      // Monitor: sampled mid-cycle, after ready has settled for the next edge.
      always @(negedge clk) begin
        #2;
        if (rst) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall)
            chk($sformatf("hold%0d", gi),
                32'({out_valid[gi], out_sym[gi], out_last[gi], out_tail[gi]}),
                32'({1'b1, prev_val}));
          if (out_valid[gi]) chk($sformatf("busy%0d", gi), 32'(busy[gi]), 32'd1);
          if (out_valid[gi] && !out_ready[gi])
            chk($sformatf("in_ready_stall%0d", gi), 32'(in_ready[gi]), 32'd0);
          if (out_valid[gi] && exp_q[gi].size() > 0) begin
            e = exp_q[gi][0];
            if ((e.fin || e.tail) && !e.last)
              chk($sformatf("in_ready_tail%0d", gi), 32'(in_ready[gi]), 32'd0);
          end
          if (out_valid[gi] && out_ready[gi]) begin
            $display("dut%0d sym=%b last=%b tail=%b", gi, out_sym[gi], out_last[gi], out_tail[gi]);
            if (exp_q[gi].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_sym%0d actual=%b required=none", gi, out_sym[gi]);
            end else begin
              e = exp_q[gi].pop_front();
              chk($sformatf("sym%0d", gi),
                  32'({out_sym[gi], out_last[gi], out_tail[gi]}),
                  32'({e.sym, e.last, e.tail}));
            end
          end
          prev_stall = out_valid[gi] && !out_ready[gi];
          prev_val   = {out_sym[gi], out_last[gi], out_tail[gi]};
        end
      end
    end
  endgenerate

  task automatic send_bit(input int i, input logic b, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_bit[i]   = b;
    in_last[i]  = l;
    forever begin
      #1;
      if (in_ready[i]) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout%0d actual=no_ready required=ready", i);
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid[i] = 1'b0;
    in_last[i]  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int i, input logic [15:0] v, input int n, input bit gaps);
    model(i, v, n, i == 0);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_bit(i, v[n-1-k], k == n - 1);
    end
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q[i].size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout%0d actual=%0d required=0", i, exp_q[i].size());
    end
    @(posedge clk);
    #1;
    chk($sformatf("end_state%0d", i), 32'(enc_state[i]), 32'd0);
    chk($sformatf("end_idle%0d", i), 32'({busy[i], out_valid[i]}), 32'd0);
  endtask

  task automatic pin_model(input string name, input logic [15:0] v, input int n, input bit term,
                           input logic [15:0] syms, input logic [7:0] lasts, input logic [7:0] tails);
    logic [15:0] gs;
    logic [7:0]  gl;
    logic [7:0]  gt;
    exp_t        e;
    gs = '0; gl = '0; gt = '0;
    model(2, v, n, term);
    while (exp_q[2].size() > 0) begin
      e  = exp_q[2].pop_front();
      gs = {gs[13:0], e.sym};
      gl = {gl[6:0], e.last};
      gt = {gt[6:0], e.tail};
    end
    chk(name, 32'({gs, gl, gt}), 32'({syms, lasts, tails}));
  endtask

  initial begin
    logic [15:0] v;
    int          len;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]   = 1'b0;
      in_bit[i]     = 1'b0;
      in_last[i]    = 1'b0;
      ready_mode[i] = 0;
    end

    // Model pins: hand-computed codewords.
    pin_model("model_1011", 16'b1011, 4, 1'b1, 16'b0000_1110_0001_0111, 8'b0000_0001, 8'b0000_0011);
    pin_model("model_1",    16'b1,    1, 1'b1, 16'b0000_0000_0011_1011, 8'b0000_0001, 8'b0000_0011);
    pin_model("model_11nt", 16'b11,   2, 1'b0, 16'b0000_0000_0000_1101, 8'b0000_0001, 8'b0000_0000);

    // Reset state.
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out%0d", i),
          32'({out_valid[i], out_sym[i], out_last[i], out_tail[i]}), 32'd0);
      chk($sformatf("rst_ctl%0d", i), 32'({in_ready[i], enc_state[i], busy[i]}), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Frame 1,0,1,1 at full rate, then with a stalling sink.
    send_frame(0, 16'b1011, 4, 1'b0);
    wait_drain(0);
    ready_mode[0] = 2;
    send_frame(0, 16'b1011, 4, 1'b0);
    wait_drain(0);

    // Single-bit frame: data symbol then two tail symbols, input blocked.
    ready_mode[0] = 0;
    send_frame(0, 16'b1, 1, 1'b0);
    chk("single_d", 32'({out_valid[0], out_sym[0], out_last[0], out_tail[0], in_ready[0]}), 32'b1_11_0_0_0);
    @(posedge clk); #1;
    chk("single_t1", 32'({out_valid[0], out_sym[0], out_last[0], out_tail[0], in_ready[0]}), 32'b1_10_0_1_0);
    @(posedge clk); #1;
    chk("single_t2", 32'({out_valid[0], out_sym[0], out_last[0], out_tail[0], in_ready[0]}), 32'b1_11_1_1_1);
    wait_drain(0);

    // Unterminated instance: frame 1,1 then immediately frame 1.
    ready_mode[1] = 0;
    send_frame(1, 16'b11, 2, 1'b0);
    send_frame(1, 16'b1, 1, 1'b0);
    wait_drain(1);

    // Reset during the first tail cycle discards the pending symbol.
    send_frame(0, 16'b1011, 4, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_state", 32'({enc_state[0], in_ready[0]}), 32'd0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(0, 16'b0, 1, 1'b0);
    wait_drain(0);

    // Randomized frames, back to back, random gaps and backpressure.
    for (int i = 0; i < 2; i++) begin
      ready_mode[i] = 1;
      for (int f = 0; f < 14; f++) begin
        len = $urandom_range(1, 8);
        v   = 16'($urandom);
        send_frame(i, v, len, ($urandom_range(0, 1) == 1));
      end
      wait_drain(i);
    end

`ifdef CONV_ENC_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_mode[0] = 1;
    for (int f = 0; f < 3; f++) send_frame(0, 16'($urandom), 4, 1'b0);
    wait_drain(0);
    chk("frame_cnt3", 32'(frame_cnt[0]), 32'd3);
    chk("sym_cnt6", 32'(sym_cnt[0]), 32'd6);
    send_frame(0, 16'b1, 1, 1'b0);
    wait_drain(0);
    chk("frame_cnt4", 32'(frame_cnt[0]), 32'd4);
    chk("sym_cnt_restart", 32'(sym_cnt[0]), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_enc_k3.md
Name: conv_enc_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder with generators G0=7 (111) and G1=5 (101). It produces the 2-bit channel symbols consumed by the Viterbi ACS/traceback chain.
- Accepts a framed serial bit stream over a valid/ready handshake and emits one symbol per input bit.
- Optionally appends K-1=2 zero tail bits per frame, so the trellis terminates in state 00 as the decoder's termination logic expects.

Parameters:
- TERM_EN, 1: 1 = append 2 zero tail bits after in_last; 0 = no tail, and the state resets to 00 after the last bit.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input bit valid
- in_ready  out  1  encoder can accept in_bit this cycle
- in_bit  in  1  information bit u
- in_last  in  1  marks the final information bit of a frame
- out_valid  out  1  out_sym valid
- out_ready  in  1  downstream accepts out_sym
- out_sym  out  2  {g0,g1} channel symbol
- out_last  out  1  final symbol of the frame (last tail symbol, or last data symbol if TERM_EN=0)
- out_tail  out  1  current symbol was produced by a tail bit
- enc_state  out  2  current trellis state {s1,s0}, where s1 is the most recent bit
- busy  out  1  FSM not in IDLE, or out_valid=1

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE, enc_state=00, tail_cnt=0.
  - out_valid=0, out_sym=00, out_last=0, out_tail=0, in_ready=0 during reset.
  - Mid-frame reset discards everything, including any pending symbol.
- Encoding, with state s={s1,s0} and input u:
  - g0 = u^s1^s0, g1 = u^s0.
  - out_sym = {g0,g1}; next state = {u,s1}.
- Output register: single stage. It loads when (!out_valid || out_ready).
  - Latency is 1 cycle from the input handshake to out_valid.
  - Full throughput: 1 symbol/cycle while out_ready=1.
- Output hold: out_sym, out_last and out_tail stay stable while out_valid && !out_ready.
- in_ready = (FSM in IDLE or DATA) && (!out_valid || out_ready).
- FSM transitions:
  - IDLE: an accepted bit encodes and moves to DATA. If that bit has in_last and TERM_EN=1, go to TAIL; if in_last and TERM_EN=0, stay IDLE.
  - DATA: accepted bits encode. An accepted bit with in_last goes to TAIL (TERM_EN=1), or to IDLE with state forced to 00 (TERM_EN=0).
  - TAIL: in_ready=0. Each output-load opportunity encodes u=0 with out_tail=1. The 2nd tail symbol sets out_last=1 and returns to IDLE with enc_state=00.
- Single-bit frame (in_last on the first bit) is legal: 1 data symbol, then 2 tail symbols.
- in_last asserted without in_valid is ignored.
- A new frame's first bit is accepted in the cycle after the last tail symbol loads; no bubble beyond that.
- enc_state is the registered state; it updates on the same edge as the output-register load.

Optional Feature:
- Macro: CONV_ENC_STATS_EN.
- Defined:
  - Adds output frame_cnt[15:0], incremented when the out_last symbol handshakes (out_valid && out_ready && out_last); wraps 0xFFFF->0.
  - Adds output sym_cnt[15:0], incremented on every output handshake and cleared on the handshake after an out_last handshake; saturates at 0xFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package (viterbi_pkg):
  - K=3, TAIL_LEN=2.
  - Generator constants G0=3'b111, G1=3'b101.
  - 2-bit state typedef.
  - FSM state encoding IDLE/DATA/TAIL.
  - Symbol typedef {g0,g1}; the ACS/ham_compute side reuses the same definitions.
- One sub-module: conv_enc_branch. It is pure combinational (state, u) -> (sym, next_state) and doubles as a golden model for the decoder bench.

Test Plan:
1. Frame 1,0,1,1 with in_last on the 4th bit, out_ready=1, TERM_EN=1 -> out_sym 11,10,00,01,01,11; out_tail=1 on the last two; out_last only on the 6th; enc_state=00 afterwards.
2. Same frame with out_ready toggling 1,0,0,1,... -> identical symbol sequence. Outputs are held stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
3. Single-bit frame in_bit=1, in_last=1 -> 11, then tail 10, 11 (out_last on the last); in_ready=0 for the 2 tail cycles.
4. TERM_EN=0, frame 1,1 then immediately 1 -> 11,01 (out_last on 01), then 11 (state restarted at 00).
5. Assert rst during the first tail cycle of frame 1 -> out_valid=0 at once, enc_state=00. A following frame with bit 0 encodes to 00.
6. CONV_ENC_STATS_EN defined, three frames of 4 bits each -> frame_cnt=3; sym_cnt=6 at the last out_last handshake, then clears on the next handshake.
